// File: rtl/bottle_feeder.sv
// bottle_feeder: pill dispenser sequencer.
// Latches a BCD pill target per bottle and a BCD bottle count, then issues
// one-cycle pill pulses spaced PULSE_GAP idle cycles apart, requesting a
// bottle change after each full bottle. Pill count and bottle number are
// kept in BCD so display logic can show them directly.
// Optional feature macro: FEED_JAM_EN (pill_seen drop sensor + jam detection).
//
// Bottle-change handshake: bot_req is high for every cycle spent in CHANGE;
// the block leaves CHANGE on the first rising edge that samples bot_ack high,
// so bot_req is low from the following cycle. bot_ack is ignored elsewhere.
module bottle_feeder #(
    parameter int PULSE_GAP   = 2,
    parameter int JAM_TIMEOUT = 8
) (
    input  logic       CLK,
    input  logic       RST_n,
    input  logic       start,
    input  logic       pause,
    input  logic [3:0] tgtL,
    input  logic [3:0] tgtH,
    input  logic [3:0] botL,
    input  logic [3:0] botH,
    input  logic       bot_ack,
    input  logic       pill_seen,
    output logic       pill_out,
    output logic       bot_req,
    output logic [3:0] nowL,
    output logic [3:0] nowH,
    output logic [3:0] seqL,
    output logic [3:0] seqH,
    output logic       busy,
    output logic       done,
    output logic       jam,
    output logic [2:0] dbg_state
);

`ifdef FEED_JAM_EN
    typedef enum logic [2:0] {
        S_IDLE = 3'd0, S_DROP = 3'd1, S_GAP = 3'd2,
        S_CHANGE = 3'd3, S_DONE = 3'd4, S_JAM = 3'd5
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE = 3'd0, S_DROP = 3'd1, S_GAP = 3'd2,
        S_CHANGE = 3'd3, S_DONE = 3'd4
    } state_t;
`endif

    localparam logic [3:0] GAP_LAST = 4'(PULSE_GAP - 1);

    // BCD digit above 9 is treated as 9
    function automatic logic [3:0] clamp_d(input logic [3:0] d);
        return (d > 4'd9) ? 4'd9 : d;
    endfunction

    // Two-digit BCD increment, ones 9 wraps with carry into tens
    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        if (v[3:0] >= 4'd9) return {v[7:4] + 4'd1, 4'd0};
        else                return {v[7:4], v[3:0] + 4'd1};
    endfunction

    state_t     r_state, w_next;
    logic [7:0] r_tgt, w_tgt_nx;
    logic [7:0] r_bot, w_bot_nx;
    logic [7:0] r_now, w_now_nx;
    logic [7:0] r_seq, w_seq_nx;
    logic [3:0] r_gap, w_gap_nx;
    logic       r_done, w_done_nx;
    logic       w_push;
    logic [7:0] w_undo_now;
    logic [7:0] w_tgt_in, w_bot_in;

    assign w_tgt_in = {clamp_d(tgtH), clamp_d(tgtL)};
    assign w_bot_in = {clamp_d(botH), clamp_d(botL)};

`ifdef FEED_JAM_EN
    // Pending-pill queue: each issued pill records its issue time and the
    // now/seq values to fall back to if it is never seen. Oldest pill is
    // always the first to time out, so only the head is aged.
    localparam int JQ_AW    = 4;
    localparam int JQ_DEPTH = 1 << JQ_AW;
    localparam logic [7:0] JAM_T8 = 8'(JAM_TIMEOUT);

    logic [7:0]       r_tick;
    logic [7:0]       r_jq_stamp [JQ_DEPTH];
    logic [7:0]       r_jq_now   [JQ_DEPTH];
    logic [7:0]       r_jq_seq   [JQ_DEPTH];
    logic [JQ_AW-1:0] r_jq_wp, r_jq_rp;
    logic             w_jq_empty;
    logic [7:0]       w_age;
    logic             w_timeout;

    assign w_jq_empty = (r_jq_wp == r_jq_rp);
    assign w_age      = r_tick - r_jq_stamp[r_jq_rp];
    assign w_timeout  = !w_jq_empty && !pill_seen && (w_age == JAM_T8) &&
                        (r_state != S_IDLE) && (r_state != S_JAM);
`else
    logic w_unused_ok;
    assign w_unused_ok = &{1'b0, pill_seen, (JAM_TIMEOUT != 0)};
`endif

    // Next-state and datapath update decisions
    always_comb begin
        w_next     = r_state;
        w_tgt_nx   = r_tgt;
        w_bot_nx   = r_bot;
        w_now_nx   = r_now;
        w_seq_nx   = r_seq;
        w_gap_nx   = r_gap;
        w_done_nx  = r_done;
        w_push     = 1'b0;
        w_undo_now = r_now;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_tgt_nx   = w_tgt_in;
                    w_bot_nx   = w_bot_in;
                    w_now_nx   = 8'h00;
                    w_seq_nx   = 8'h01;
                    w_done_nx  = 1'b0;
                    w_gap_nx   = 4'd0;
                    w_undo_now = 8'h00;
                    if (w_tgt_in == 8'h00 || w_bot_in == 8'h00) begin
                        w_next    = S_DONE;
                        w_seq_nx  = 8'h00;
                        w_done_nx = 1'b1;
                    end else if (!pause) begin
                        // count rises together with the pulse it belongs to
                        w_next   = S_DROP;
                        w_now_nx = 8'h01;
                        w_push   = 1'b1;
                    end else begin
                        w_next = S_GAP;
                    end
                end
            end
            S_DROP: begin
                w_gap_nx = 4'd0;
                w_next   = (r_now == r_tgt) ? S_CHANGE : S_GAP;
            end
            S_GAP: begin
                if (!pause) begin
                    if (r_gap == GAP_LAST) begin
                        w_next   = S_DROP;
                        w_gap_nx = 4'd0;
                        w_now_nx = bcd_inc(r_now);
                        w_push   = 1'b1;
                    end else begin
                        w_gap_nx = r_gap + 4'd1;
                    end
                end
            end
            S_CHANGE: begin
                if (bot_ack) begin
                    if (r_seq == r_bot) begin
                        w_next    = S_DONE;
                        w_done_nx = 1'b1;
                    end else begin
                        w_next   = S_GAP;
                        w_seq_nx = bcd_inc(r_seq);
                        w_now_nx = 8'h00;
                        w_gap_nx = 4'd0;
                    end
                end
            end
            S_DONE: begin
                if (!start) w_next = S_IDLE;
            end
`ifdef FEED_JAM_EN
            S_JAM: begin
                if (start) begin
                    w_next   = S_DROP;
                    w_now_nx = bcd_inc(r_now);
                    w_push   = 1'b1;
                end
            end
`endif
            default: w_next = S_IDLE;
        endcase
`ifdef FEED_JAM_EN
        // A missed pill rolls the counts back to just before it was issued
        if (w_timeout) begin
            w_next    = S_JAM;
            w_now_nx  = r_jq_now[r_jq_rp];
            w_seq_nx  = r_jq_seq[r_jq_rp];
            w_gap_nx  = 4'd0;
            w_done_nx = 1'b0;
            w_push    = 1'b0;
        end
`endif
    end

    // State and datapath registers
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            r_state <= S_IDLE;
            r_tgt   <= 8'h00;
            r_bot   <= 8'h00;
            r_now   <= 8'h00;
            r_seq   <= 8'h00;
            r_gap   <= 4'd0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_tgt   <= w_tgt_nx;
            r_bot   <= w_bot_nx;
            r_now   <= w_now_nx;
            r_seq   <= w_seq_nx;
            r_gap   <= w_gap_nx;
            r_done  <= w_done_nx;
        end
    end

`ifdef FEED_JAM_EN
    // Pending-pill pointers and time base
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            r_tick  <= 8'd0;
            r_jq_wp <= '0;
            r_jq_rp <= '0;
        end else begin
            r_tick <= r_tick + 8'd1;
            if (r_state == S_IDLE || w_timeout) r_jq_rp <= r_jq_wp;
            else if (!w_jq_empty && pill_seen) r_jq_rp <= r_jq_rp + 1'b1;
            if (w_push) r_jq_wp <= r_jq_wp + 1'b1;
        end
    end

    // Pending-pill payload (no reset needed, guarded by the pointers)
    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_jq_stamp[r_jq_wp] <= r_tick;
            r_jq_now[r_jq_wp]   <= w_undo_now;
            r_jq_seq[r_jq_wp]   <= w_seq_nx;
        end
    end

    assign jam  = (r_state == S_JAM);
    assign busy = (r_state == S_DROP) || (r_state == S_GAP) ||
                  (r_state == S_CHANGE) || (r_state == S_JAM);
`else
    assign jam  = 1'b0;
    assign busy = (r_state == S_DROP) || (r_state == S_GAP) ||
                  (r_state == S_CHANGE);
`endif

    assign pill_out  = (r_state == S_DROP);
    assign bot_req   = (r_state == S_CHANGE);
    assign done      = r_done;
    assign nowH      = r_now[7:4];
    assign nowL      = r_now[3:0];
    assign seqH      = r_seq[7:4];
    assign seqL      = r_seq[3:0];
    assign dbg_state = r_state;

endmodule

// File: tb/tb_bottle_feeder.sv
// Bench for bottle_feeder: vector table, randomized runs against a
// pill/bottle list model, and hand sequences for pause, ack hold, reset
// and (with FEED_JAM_EN) jam recovery.
module tb_bottle_feeder;
    localparam int P = 2;

    logic       CLK, RST_n, start, pause, bot_ack, pill_seen;
    logic [3:0] tgtL, tgtH, botL, botH;
    logic       pill_out, bot_req, busy, done, jam;
    logic [3:0] nowL, nowH, seqL, seqH;
    logic [2:0] dbg_state;

    int n_checks = 0;
    int n_fail   = 0;
    logic echo_en;

    bottle_feeder #(.PULSE_GAP(P), .JAM_TIMEOUT(8)) dut (
        .CLK(CLK), .RST_n(RST_n), .start(start), .pause(pause),
        .tgtL(tgtL), .tgtH(tgtH), .botL(botL), .botH(botH),
        .bot_ack(bot_ack), .pill_seen(pill_seen),
        .pill_out(pill_out), .bot_req(bot_req),
        .nowL(nowL), .nowH(nowH), .seqL(seqL), .seqH(seqH),
        .busy(busy), .done(done), .jam(jam), .dbg_state(dbg_state)
    );

    // clock
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // drop sensor echoes each pill back while enabled
    initial begin
        pill_seen = 1'b0;
        forever begin
            @(negedge CLK);
            pill_seen = echo_en && pill_out;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int clamp_dec(input logic [7:0] v);
        int h, l;
        h = (v[7:4] > 9) ? 9 : int'(v[7:4]);
        l = (v[3:0] > 9) ? 9 : int'(v[3:0]);
        return h * 10 + l;
    endfunction

    function automatic logic [7:0] to_bcd(input int n);
        logic [7:0] r;
        r[7:4] = 4'(n / 10);
        r[3:0] = 4'(n % 10);
        return r;
    endfunction

    task automatic do_reset();
        RST_n = 1'b0;
        start = 1'b0; pause = 1'b0; bot_ack = 1'b0;
        @(negedge CLK);
        RST_n = 1'b1;
        @(negedge CLK);
    endtask

    // One complete run; model: bottles 1..B each receive pills 1..T in order.
    task automatic run_feed(input logic [7:0] t_in, input logic [7:0] b_in, input int ack_dly,
                            output int n_pulse, output logic [7:0] now_f, output logic [7:0] seq_f);
        int t, b, cyc, last, req_n, req_len, overlap;
        logic ack_prev, req_prev, fin;
        logic [15:0] exp_q[$];
        logic [15:0] e;
        t = clamp_dec(t_in);
        b = clamp_dec(b_in);
        if (t != 0 && b != 0)
            for (int bb = 1; bb <= b; bb++)
                for (int pp = 1; pp <= t; pp++)
                    exp_q.push_back({to_bcd(pp), to_bcd(bb)});
        tgtH = t_in[7:4]; tgtL = t_in[3:0];
        botH = b_in[7:4]; botL = b_in[3:0];
        start = 1'b1;
        n_pulse = 0; cyc = 0; last = -1; req_n = 0; req_len = 0; overlap = 0;
        ack_prev = 1'b0; req_prev = 1'b0; fin = 1'b0;
        while (!fin && cyc < 4000) begin
            @(negedge CLK);
            cyc++;
            if (cyc == 1) begin
                start = 1'b0;
                check("latency", {31'd0, pill_out}, (t != 0 && b != 0) ? 1 : 0);
            end
            if (pill_out && bot_req) overlap++;
            if (ack_prev) begin
                check("req_drop", {31'd0, bot_req}, 0);
                bot_ack = 1'b0;
                ack_prev = 1'b0;
                last = cyc - 1;
            end
            if (pill_out) begin
                n_pulse++;
                if (exp_q.size() == 0) check("extra_pulse", 1, 0);
                else begin
                    e = exp_q.pop_front();
                    check("pulse_now_seq", {16'd0, nowH, nowL, seqH, seqL}, {16'd0, e});
                end
                check("busy_run", {31'd0, busy}, 1);
                if (last >= 0) check("spacing", cyc - last, P + 1);
                last = cyc;
            end
            if (bot_req) begin
                if (!req_prev) begin
                    req_n++;
                    req_len = 0;
                end
                req_len++;
                if (req_len == ack_dly) begin
                    bot_ack = 1'b1;
                    ack_prev = 1'b1;
                end
            end
            req_prev = bot_req;
            if (done) fin = 1'b1;
        end
        if (!fin) check("run_timeout", 0, 1);
        bot_ack = 1'b0;
        check("pulse_count", n_pulse, t * b);
        check("exp_q_empty", exp_q.size(), 0);
        check("req_count", req_n, (t != 0 && b != 0) ? b : 0);
        check("overlap", overlap, 0);
        check("done_busy", {31'd0, busy}, 0);
        now_f = {nowH, nowL};
        seq_f = {seqH, seqL};
        repeat (2) @(negedge CLK);
        check("done_hold_idle", {31'd0, done}, 1);
    endtask

    typedef struct {
        logic [7:0] tgt;
        logic [7:0] bot;
        int         ack;
        logic [7:0] now_e;
        logic [7:0] seq_e;
        int         np_e;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int np, quiet;
        logic [7:0] nf, sf, rt, rb;
        logic found;

        vecs[0] = '{8'h03, 8'h02, 2,  8'h03, 8'h02, 6};
        vecs[1] = '{8'h12, 8'h01, 1,  8'h12, 8'h01, 12};
        vecs[2] = '{8'h00, 8'h05, 1,  8'h00, 8'h00, 0};
        vecs[3] = '{8'h04, 8'h00, 1,  8'h00, 8'h00, 0};
        vecs[4] = '{8'h01, 8'h03, 20, 8'h01, 8'h03, 3};
        vecs[5] = '{8'h0C, 8'h02, 3,  8'h09, 8'h02, 18};
        vecs[6] = '{8'hA1, 8'h01, 1,  8'h91, 8'h01, 91};

        RST_n = 1'b0; start = 1'b0; pause = 1'b0; bot_ack = 1'b0; echo_en = 1'b1;
        tgtL = 4'd0; tgtH = 4'd0; botL = 4'd0; botH = 4'd0;
        repeat (3) @(negedge CLK);
        check("reset_outputs", {9'd0, pill_out, bot_req, busy, done, jam, nowH, nowL, seqH, seqL}, 0);
        RST_n = 1'b1;
        @(negedge CLK);

        // vector table
        for (int i = 0; i < 7; i++) begin
            run_feed(vecs[i].tgt, vecs[i].bot, vecs[i].ack, np, nf, sf);
            check("vec_pulses", np, vecs[i].np_e);
            check("vec_now", {24'd0, nf}, {24'd0, vecs[i].now_e});
            check("vec_seq", {24'd0, sf}, {24'd0, vecs[i].seq_e});
        end

        // randomized runs
        for (int i = 0; i < 6; i++) begin
            rt = {4'($urandom_range(0, 1)), 4'($urandom_range(0, 15))};
            rb = {4'd0, 4'($urandom_range(0, 4))};
            run_feed(rt, rb, $urandom_range(1, 5), np, nf, sf);
            if (clamp_dec(rt) != 0 && clamp_dec(rb) != 0) begin
                check("rnd_now", {24'd0, nf}, {24'd0, to_bcd(clamp_dec(rt))});
                check("rnd_seq", {24'd0, sf}, {24'd0, to_bcd(clamp_dec(rb))});
            end else begin
                check("rnd_zero", {16'd0, nf, sf}, 0);
            end
        end

        // pause mid-GAP freezes the gap count
        tgtH = 4'd0; tgtL = 4'd5; botH = 4'd0; botL = 4'd1;
        start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        check("p_first", {31'd0, pill_out}, 1);
        pause = 1'b1;
        quiet = 0;
        for (int i = 1; i <= 11; i++) begin
            @(negedge CLK);
            if (pill_out) quiet++;
            if (i == 10) pause = 1'b0;
        end
        check("p_quiet", quiet, 0);
        @(negedge CLK);
        check("p_resume", {23'd0, pill_out, nowH, nowL}, {23'd0, 1'b1, 8'h02});
        do_reset();

        // reset during the gap of bottle 2
        tgtH = 4'd0; tgtL = 4'd3; botH = 4'd0; botL = 4'd2;
        start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge CLK);
            bot_ack = bot_req;
            if (seqL == 4'd2 && !bot_req && !pill_out) found = 1'b1;
        end
        bot_ack = 1'b0;
        check("r_reach_b2", {31'd0, found}, 1);
        RST_n = 1'b0;
        #1;
        check("r_outputs", {9'd0, pill_out, bot_req, busy, done, jam, nowH, nowL, seqH, seqL}, 0);
        @(negedge CLK);
        RST_n = 1'b1;
        @(negedge CLK);
        start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        check("r_restart", {15'd0, pill_out, nowH, nowL, seqH, seqL}, {15'd0, 1'b1, 8'h01, 8'h01});
        do_reset();

`ifdef FEED_JAM_EN
        // second pill never seen: jam, then start re-issues it
        tgtH = 4'd0; tgtL = 4'd5; botH = 4'd0; botL = 4'd1;
        start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        check("j_first", {31'd0, pill_out}, 1);
        for (int c = 2; c <= 11; c++) begin
            @(negedge CLK);
            if (c == 2) echo_en = 1'b0;
            if (c == 11) check("j_not_yet", {31'd0, jam}, 0);
        end
        @(negedge CLK);
        check("j_flag", {13'd0, jam, busy, pill_out, nowH, nowL, seqH, seqL},
              {13'd0, 1'b1, 1'b1, 1'b0, 8'h01, 8'h01});
        start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        check("j_resume", {21'd0, jam, pill_out, nowH, nowL, 2'b00}, {21'd0, 1'b0, 1'b1, 8'h02, 2'b00});
        echo_en = 1'b1;
        do_reset();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // absolute time limit
    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/bottle_feeder.md
Name: bottle_feeder

Overview:
- Pill dispenser sequencer; the transmitting end of the pill-count path.
- Takes the BCD per-bottle pill target and the BCD bottle target, then emits one-cycle pill pulses toward the counting logic.
- Requests a bottle change at each full bottle and waits for an acknowledge before refilling.
- Reports the current pill count and bottle sequence number in BCD, so the page/display logic can show them unchanged.

Parameters:
- PULSE_GAP, 2, idle cycles between consecutive pill pulses (1..15).
- JAM_TIMEOUT, 8, cycles allowed for pill_seen after a pulse (used only with FEED_JAM_EN).

Ports:
- CLK  in  1  system clock, all state updates on rising edge
- RST_n  in  1  asynchronous active-low reset
- start  in  1  level; begin a run when sampled high in IDLE
- pause  in  1  level; hold feeding while high
- tgtL, tgtH  in  4 each  per-bottle pill target, BCD ones/tens
- botL, botH  in  4 each  number of bottles, BCD ones/tens
- bot_ack  in  1  bottle replaced/ready acknowledge
- pill_seen  in  1  drop sensor (FEED_JAM_EN only; ignored otherwise)
- pill_out  out  1  one-cycle pill pulse
- bot_req  out  1  bottle change request
- nowL, nowH  out  4 each  pills in current bottle, BCD
- seqL, seqH  out  4 each  current bottle number, BCD
- busy  out  1  run in progress
- done  out  1  all bottles filled
- jam  out  1  jam flagged (FEED_JAM_EN only; constant 0 otherwise)

Behaviour:
- Reset state (RST_n low, any time, including mid-run):
  - State IDLE.
  - All outputs 0: pill_out, bot_req, busy, done, jam, now*=0, seq*=0.
  - Gap counter 0; latched targets 0.
- Input clamping: any input BCD digit >9 is treated as 9 when latched.
- States: IDLE, DROP, GAP, CHANGE, DONE (plus JAM with the option).
- IDLE:
  - On start=1, latch the clamped tgt/bot values, set now=00, seq=01, busy=1 and done=0.
  - If the latched tgt=00 or bot=00, go straight to DONE with seq=00. No pulses are issued.
  - Otherwise go to DROP if pause=0, else GAP with the gap counter at 0.
- DROP (exactly one cycle):
  - pill_out=1 and now increments by 1 in BCD in the same cycle: ones 9 wraps to 0 with a carry into tens.
  - If the new now equals the latched tgt, go to CHANGE; else go to GAP.
- GAP:
  - The gap counter counts PULSE_GAP cycles, then the block goes to DROP.
  - While pause=1 the counter freezes and the state holds.
  - Steady pulse period is PULSE_GAP+1 cycles.
- CHANGE (bot_req=1):
  - bot_req stays high until bot_ack is sampled high; pause is ignored here.
  - If seq equals bot, go to DONE.
  - Otherwise seq increments in BCD, now is cleared to 00, and the block goes to GAP.
  - bot_req is 0 from the cycle after the ack.
  - bot_ack while not in CHANGE is ignored.
- DONE:
  - done=1, busy=0; now and seq hold their final values.
  - Return to IDLE when start is sampled 0; done stays 1 in IDLE until the next run starts.
- start dropping mid-run is ignored; the only abort is reset.
- pill_out and bot_req are never high in the same cycle.
- Latency: start sampled at edge k gives pill_out high in the cycle after edge k, when pause=0.

Optional Feature:
- Macro FEED_JAM_EN.
- When defined:
  - After each pill_out, pill_seen must pulse within JAM_TIMEOUT cycles.
  - Timeout moves the block to JAM: jam=1, busy=1, no pulses, counters hold.
  - In JAM, start=1 clears jam and resumes in DROP, re-issuing the missing pill without incrementing now twice. The pill's count is undone on the timeout.
  - pill_seen arriving while the previous pill is still pending satisfies that pill only.
- When not defined:
  - pill_seen is unused and jam is tied to 0.
  - There is no JAM state and no timeout counter.

Test Plan:
- Basic run: tgt=03, bot=02, PULSE_GAP=2, ack 2 cycles after each bot_req -> 6 pill_out pulses spaced 3 cycles apart, now 1,2,3 per bottle, seq 01 then 02, two bot_req, done=1 with now=03, seq=02.
- BCD carry: tgt=12, bot=01 -> now sequence 01..09,10,11,12, nowH=1 after the tenth pulse, then one bot_req.
- Zero target: tgt=00, bot=05, start -> DONE next cycle, no pill_out, seq=00, done=1.
- Pause and ack hold: pause=1 for 10 cycles mid-GAP -> no pulses and the counter frozen; withhold bot_ack for 20 cycles -> bot_req high for all 20, no pill_out.
- Reset mid-run: RST_n low during GAP of bottle 2 -> all outputs 0 immediately; a later start restarts at seq=01, now=00.
- With FEED_JAM_EN: JAM_TIMEOUT=8, no pill_seen after the second pulse -> jam=1 at cycle 8 after that pulse with now=01; start=1 -> pill re-issued, now=02, jam=0.
